conv1x1_seq_ctrl: RTL and testbench

- Address/strobe sequencer for a time-multiplexed 1x1 convolution engine with one MAC and single-port tensor, weight and bias memories.
- Walks every output element (batch, out-channel, out-row, out-col) and, for each, every input channel.
- Emits memory read addresses plus accumulator and output-write strobes; the arithmetic stays in the datapath.
- Output geometry matches conv1x1: PADDING=0, OUT_H=(IN_HEIGHT-1)/STRIDE+1, OUT_W=(IN_WIDTH-1)/STRIDE+1.

---
 rtl/conv_pkg.sv | 14 +
 rtl/nested_counter.sv | 34 +++
 rtl/conv1x1_seq_ctrl.sv | 170 +++++++++++++++++
 tb/tb_conv1x1_seq_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and elaboration-time helpers for the 1x1 convolution sequencer.
package conv_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    function automatic int clog2m1(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

    function automatic int OUT_DIM(input int in_dim, input int stride);
        return (in_dim - 1) / stride + 1;
    endfunction

endpackage

// File: rtl/nested_counter.sv
// Wrapping 0..MAX-1 counter; carry_o fires on the enabled wrap so levels can be chained.
module nested_counter
    import conv_pkg::*;
#(
    parameter int MAX = 1,
    localparam int W = clog2m1(MAX)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         last_o,
    output logic         carry_o
);

    logic [W-1:0] cnt_q, cnt_d;

    assign last_o  = (cnt_q == W'(MAX - 1));
    assign carry_o = en_i && last_o;
    assign cnt_o   = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)     cnt_d = '0;
        else if (en_i) cnt_d = last_o ? '0 : cnt_q + W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

endmodule

// File: rtl/conv1x1_seq_ctrl.sv
// Address/strobe sequencer for a single-MAC 1x1 convolution: walks b,oc,oh,ow,ic and
// issues tensor/weight/bias reads plus accumulate and output-write strobes.
module conv1x1_seq_ctrl
    import conv_pkg::*;
#(
    parameter int BATCH_SIZE   = 1,
    parameter int IN_CHANNELS  = 1,
    parameter int OUT_CHANNELS = 1,
    parameter int IN_HEIGHT    = 4,
    parameter int IN_WIDTH     = 4,
    parameter int STRIDE       = 1,
    localparam int OUT_H  = OUT_DIM(IN_HEIGHT, STRIDE),
    localparam int OUT_W  = OUT_DIM(IN_WIDTH, STRIDE),
    localparam int IN_AW  = clog2m1(BATCH_SIZE * IN_CHANNELS * IN_HEIGHT * IN_WIDTH),
    localparam int W_AW   = clog2m1(OUT_CHANNELS * IN_CHANNELS),
    localparam int B_AW   = clog2m1(OUT_CHANNELS),
    localparam int OUT_AW = clog2m1(BATCH_SIZE * OUT_CHANNELS * OUT_H * OUT_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stall,
    output logic              busy,
    output logic              done,
    output logic              rd_valid,
    output logic [IN_AW-1:0]  in_addr,
    output logic [W_AW-1:0]   w_addr,
    output logic [B_AW-1:0]   b_addr,
    output logic              acc_first,
    output logic              acc_en,
    output logic              out_we,
    output logic [OUT_AW-1:0] out_addr
);

    localparam logic [IN_AW-1:0] IC_STEP  = IN_AW'(IN_HEIGHT * IN_WIDTH);
    localparam logic [IN_AW-1:0] PIX_STEP = IN_AW'(STRIDE);
    localparam logic [IN_AW-1:0] ROW_STEP = IN_AW'(STRIDE * IN_WIDTH);
    localparam logic [IN_AW-1:0] BAT_STEP = IN_AW'(IN_CHANNELS * IN_HEIGHT * IN_WIDTH);
    localparam logic [W_AW-1:0]  OC_STEP  = W_AW'(IN_CHANNELS);

    state_e state_q, state_d;
    logic   drain_q, drain_d;
    logic   issue, clr;

    assign issue    = (state_q == RUN) && !stall;
    assign clr      = (state_q == IDLE);
    assign rd_valid = issue;

    logic [clog2m1(IN_CHANNELS)-1:0]  ic_cnt;
    logic [clog2m1(OUT_W)-1:0]        ow_cnt;
    logic [clog2m1(OUT_H)-1:0]        oh_cnt;
    logic [B_AW-1:0]                  oc_cnt;
    logic [clog2m1(BATCH_SIZE)-1:0]   b_cnt;
    logic ic_last, ow_last, oh_last, oc_last, b_last;
    logic ic_cy, ow_cy, oh_cy, oc_cy, b_cy;
    logic unused_cnt;

    nested_counter #(.MAX(IN_CHANNELS))  u_ic (.clk(clk), .rst(rst), .clr_i(clr), .en_i(issue),
        .cnt_o(ic_cnt), .last_o(ic_last), .carry_o(ic_cy));
    nested_counter #(.MAX(OUT_W))        u_ow (.clk(clk), .rst(rst), .clr_i(clr), .en_i(ic_cy),
        .cnt_o(ow_cnt), .last_o(ow_last), .carry_o(ow_cy));
    nested_counter #(.MAX(OUT_H))        u_oh (.clk(clk), .rst(rst), .clr_i(clr), .en_i(ow_cy),
        .cnt_o(oh_cnt), .last_o(oh_last), .carry_o(oh_cy));
    nested_counter #(.MAX(OUT_CHANNELS)) u_oc (.clk(clk), .rst(rst), .clr_i(clr), .en_i(oh_cy),
        .cnt_o(oc_cnt), .last_o(oc_last), .carry_o(oc_cy));
    nested_counter #(.MAX(BATCH_SIZE))   u_b  (.clk(clk), .rst(rst), .clr_i(clr), .en_i(oc_cy),
        .cnt_o(b_cnt), .last_o(b_last), .carry_o(b_cy));

    assign unused_cnt = ^{ow_cnt, oh_cnt, b_cnt};
    assign b_addr     = oc_cnt;

    // Address bases per loop level; each wrap reloads the inner level from the one above it.
    logic [IN_AW-1:0]  in_q, in_d, pix_q, pix_d, row_q, row_d, bat_q, bat_d;
    logic [W_AW-1:0]   w_q, w_d, wb_q, wb_d;
    logic [OUT_AW-1:0] oa_q, oa_d;

    always_comb begin
        in_d = in_q; pix_d = pix_q; row_d = row_q; bat_d = bat_q;
        w_d = w_q; wb_d = wb_q; oa_d = oa_q;
        if (clr) begin
            in_d = '0; pix_d = '0; row_d = '0; bat_d = '0;
            w_d = '0; wb_d = '0; oa_d = '0;
        end else if (issue) begin
            if (!ic_last) begin
                in_d = in_q + IC_STEP;
                w_d  = w_q + W_AW'(1);
            end else begin
                oa_d = oa_q + OUT_AW'(1);
                w_d  = wb_q;
                if (!ow_last) begin
                    pix_d = pix_q + PIX_STEP;
                    in_d  = pix_q + PIX_STEP;
                end else if (!oh_last) begin
                    row_d = row_q + ROW_STEP;
                    pix_d = row_q + ROW_STEP;
                    in_d  = row_q + ROW_STEP;
                end else if (!oc_last) begin
                    row_d = bat_q; pix_d = bat_q; in_d = bat_q;
                    wb_d  = wb_q + OC_STEP;
                    w_d   = wb_q + OC_STEP;
                end else if (!b_last) begin
                    bat_d = bat_q + BAT_STEP;
                    row_d = bat_q + BAT_STEP;
                    pix_d = bat_q + BAT_STEP;
                    in_d  = bat_q + BAT_STEP;
                    wb_d  = '0; w_d = '0;
                end else begin
                    in_d = '0; pix_d = '0; row_d = '0; bat_d = '0;
                    w_d = '0; wb_d = '0; oa_d = '0;
                end
            end
        end
    end

    assign in_addr = in_q;
    assign w_addr  = w_q;

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        unique case (state_q)
            IDLE:  if (start) state_d = RUN;
            RUN: begin
                drain_d = 1'b0;
                if (b_cy) state_d = DRAIN;
            end
            DRAIN: if (!stall) begin
                if (drain_q) state_d = DONE;
                else         drain_d = 1'b1;
            end
            DONE:  if (!stall) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE) && !stall;

    // Two-stage strobe pipe: stage 1 aligns with read data, stage 2 with the output write.
    logic              af_q, ae_q, last1_q, we_q;
    logic [OUT_AW-1:0] oa1_q, oa2_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE; drain_q <= 1'b0;
            in_q <= '0; pix_q <= '0; row_q <= '0; bat_q <= '0;
            w_q <= '0; wb_q <= '0; oa_q <= '0;
            af_q <= 1'b0; ae_q <= 1'b0; last1_q <= 1'b0; we_q <= 1'b0;
            oa1_q <= '0; oa2_q <= '0;
        end else begin
            state_q <= state_d; drain_q <= drain_d;
            in_q <= in_d; pix_q <= pix_d; row_q <= row_d; bat_q <= bat_d;
            w_q <= w_d; wb_q <= wb_d; oa_q <= oa_d;
            if (!stall) begin
                ae_q    <= issue;
                af_q    <= issue && (ic_cnt == '0);
                last1_q <= issue && ic_last;
                oa1_q   <= oa_q;
                we_q    <= last1_q;
                oa2_q   <= oa1_q;
            end
        end
    end

    assign acc_first = af_q && !stall;
    assign acc_en    = ae_q && !stall;
    assign out_we    = we_q && !stall;
    assign out_addr  = oa2_q;

endmodule

// File: tb/tb_conv1x1_seq_ctrl.sv
// Directed bench for conv1x1_seq_ctrl: vector table against recorded traces plus a
// formula-based address model and per-run scoreboard on two configurations.
module tb_conv1x1_seq_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int   sel = 0;
    logic start = 1'b0, stall = 1'b0;

    logic start_a, stall_a, start_b, stall_b;
    assign start_a = start && (sel == 0);
    assign stall_a = stall && (sel == 0);
    assign start_b = start && (sel != 0);
    assign stall_b = stall && (sel != 0);

    logic       busy_a, done_a, rv_a, af_a, ae_a, we_a;
    logic [5:0] in_a;
    logic [2:0] w_a, oa_a;
    logic [0:0] b_a;
    logic       busy_b, done_b, rv_b, af_b, ae_b, we_b;
    logic [1:0] in_b, oa_b;
    logic [0:0] w_b, b_b;

    conv1x1_seq_ctrl #(.BATCH_SIZE(1), .IN_CHANNELS(3), .OUT_CHANNELS(2),
                       .IN_HEIGHT(4), .IN_WIDTH(4), .STRIDE(2)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .stall(stall_a), .busy(busy_a), .done(done_a),
        .rd_valid(rv_a), .in_addr(in_a), .w_addr(w_a), .b_addr(b_a), .acc_first(af_a),
        .acc_en(ae_a), .out_we(we_a), .out_addr(oa_a));

    conv1x1_seq_ctrl #(.BATCH_SIZE(1), .IN_CHANNELS(1), .OUT_CHANNELS(1),
                       .IN_HEIGHT(2), .IN_WIDTH(2), .STRIDE(1)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .stall(stall_b), .busy(busy_b), .done(done_b),
        .rd_valid(rv_b), .in_addr(in_b), .w_addr(w_b), .b_addr(b_b), .acc_first(af_b),
        .acc_en(ae_b), .out_we(we_b), .out_addr(oa_b));

    int m_busy, m_done, m_rv, m_in, m_w, m_b, m_af, m_ae, m_we, m_oa;
    assign m_busy = (sel != 0) ? int'(busy_b) : int'(busy_a);
    assign m_done = (sel != 0) ? int'(done_b) : int'(done_a);
    assign m_rv   = (sel != 0) ? int'(rv_b)   : int'(rv_a);
    assign m_in   = (sel != 0) ? int'(in_b)   : int'(in_a);
    assign m_w    = (sel != 0) ? int'(w_b)    : int'(w_a);
    assign m_b    = (sel != 0) ? int'(b_b)    : int'(b_a);
    assign m_af   = (sel != 0) ? int'(af_b)   : int'(af_a);
    assign m_ae   = (sel != 0) ? int'(ae_b)   : int'(ae_a);
    assign m_we   = (sel != 0) ? int'(we_b)   : int'(we_a);
    assign m_oa   = (sel != 0) ? int'(oa_b)   : int'(oa_a);

    typedef struct {int rv, in, w, b, af, ae, we, oa, dn, bz;} sample_t;
    typedef struct {int sel, cyc, rv, in, w, b, af, ae, we, oa, dn, bz;} vec_t;

    sample_t tr[64];
    vec_t    tbl[$];
    int      checks = 0, errors = 0;
    int      cB, cIC, cOC, cIH, cIW, cS;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_cfg(input int s);
        sel = s;
        if (s == 0) begin cB = 1; cIC = 3; cOC = 2; cIH = 4; cIW = 4; cS = 2; end
        else        begin cB = 1; cIC = 1; cOC = 1; cIH = 2; cIW = 2; cS = 1; end
    endtask

    task automatic check_vecs();
        foreach (tbl[i]) begin
            if (tbl[i].sel == sel) begin
                sample_t a;
                a = tr[tbl[i].cyc];
                chk($sformatf("vec%0d c%0d rd_valid", sel, tbl[i].cyc), a.rv, tbl[i].rv);
                if (tbl[i].rv != 0) begin
                    chk($sformatf("vec%0d c%0d in_addr", sel, tbl[i].cyc), a.in, tbl[i].in);
                    chk($sformatf("vec%0d c%0d w_addr", sel, tbl[i].cyc), a.w, tbl[i].w);
                    chk($sformatf("vec%0d c%0d b_addr", sel, tbl[i].cyc), a.b, tbl[i].b);
                end
                chk($sformatf("vec%0d c%0d acc_first", sel, tbl[i].cyc), a.af, tbl[i].af);
                chk($sformatf("vec%0d c%0d acc_en", sel, tbl[i].cyc), a.ae, tbl[i].ae);
                chk($sformatf("vec%0d c%0d out_we", sel, tbl[i].cyc), a.we, tbl[i].we);
                if (tbl[i].we != 0)
                    chk($sformatf("vec%0d c%0d out_addr", sel, tbl[i].cyc), a.oa, tbl[i].oa);
                chk($sformatf("vec%0d c%0d done", sel, tbl[i].cyc), a.dn, tbl[i].dn);
                chk($sformatf("vec%0d c%0d busy", sel, tbl[i].cyc), a.bz, tbl[i].bz);
            end
        end
    endtask

    // One run from a start pulse at edge 0; cycle c is the interval after edge c.
    task automatic run(input int s_at, input int s_len, input int rep_at, input bit hold);
        int oh, ow, n_out, n, exp_done, lim;
        int qi[$], qw[$], qb[$];
        int issue, mism, we_cnt, dup, missing, acc_cnt, acc_bad, af_bad, stall_bad;
        int done_cnt, done_cyc, busy_cnt;
        bit seen[64];
        oh = (cIH - 1) / cS + 1;
        ow = (cIW - 1) / cS + 1;
        n_out = cB * cOC * oh * ow;
        n = n_out * cIC;
        exp_done = n + 3 + s_len;
        lim = exp_done + 1;
        for (int b = 0; b < cB; b++)
            for (int oc = 0; oc < cOC; oc++)
                for (int y = 0; y < oh; y++)
                    for (int x = 0; x < ow; x++)
                        for (int ic = 0; ic < cIC; ic++) begin
                            qi.push_back(((b * cIC + ic) * cIH + y * cS) * cIW + x * cS);
                            qw.push_back(oc * cIC + ic);
                            qb.push_back(oc);
                        end
        issue = 0; mism = 0; we_cnt = 0; dup = 0; missing = 0; acc_cnt = 0; acc_bad = 0;
        af_bad = 0; stall_bad = 0; done_cnt = 0; done_cyc = -1; busy_cnt = 0;
        foreach (seen[i]) seen[i] = 1'b0;
        @(negedge clk); start = 1'b1; stall = 1'b0;
        @(posedge clk); #1;
        for (int c = 1; c <= lim; c++) begin
            stall = (c >= s_at) && (c < s_at + s_len);
            start = (hold && c <= exp_done) || (c == rep_at);
            @(negedge clk);
            if (c < 64) tr[c] = '{m_rv, m_in, m_w, m_b, m_af, m_ae, m_we, m_oa, m_done, m_busy};
            if (stall && (m_rv | m_af | m_ae | m_we | m_done) != 0) stall_bad++;
            if (m_rv != 0) begin
                if (issue >= n) mism++;
                else if (m_in != qi[issue] || m_w != qw[issue] || m_b != qb[issue]) mism++;
                issue++;
            end
            if (m_we != 0) begin
                if (acc_cnt != cIC) acc_bad++;
                acc_cnt = 0;
                we_cnt++;
                if (m_oa < 64) begin
                    if (seen[m_oa]) dup++;
                    seen[m_oa] = 1'b1;
                end
            end
            if (m_ae != 0) acc_cnt++;
            if (cIC == 1 ? (m_af != m_ae) : (m_af != 0 && m_ae == 0)) af_bad++;
            if (m_done != 0) begin done_cnt++; done_cyc = c; end
            if (m_busy != 0) busy_cnt++;
            @(posedge clk); #1;
        end
        start = 1'b0; stall = 1'b0;
        for (int o = 0; o < n_out; o++) if (!seen[o]) missing++;
        chk("issue count", issue, n);
        chk("address stream mismatches", mism, 0);
        chk("out_we count", we_cnt, n_out);
        chk("out_addr duplicates", dup, 0);
        chk("out_addr missing", missing, 0);
        chk("acc_en per output violations", acc_bad, 0);
        chk("acc_en after last out_we", acc_cnt, 0);
        chk("acc_first/acc_en violations", af_bad, 0);
        chk("strobes while stalled", stall_bad, 0);
        chk("done pulses", done_cnt, 1);
        chk("done cycle", done_cyc, exp_done);
        chk("busy cycles", busy_cnt, exp_done);
    endtask

    initial begin
        int dn_cnt, bz_cnt;
        // sel, cyc, rv, in, w, b, af, ae, we, oa, done, busy
        tbl.push_back(vec_t'{0,  1, 1,  0, 0, 0, 0, 0, 0, 0, 0, 1});
        tbl.push_back(vec_t'{0,  2, 1, 16, 1, 0, 1, 1, 0, 0, 0, 1});
        tbl.push_back(vec_t'{0,  3, 1, 32, 2, 0, 0, 1, 0, 0, 0, 1});
        tbl.push_back(vec_t'{0,  4, 1,  2, 0, 0, 0, 1, 0, 0, 0, 1});
        tbl.push_back(vec_t'{0,  5, 1, 18, 1, 0, 1, 1, 1, 0, 0, 1});
        tbl.push_back(vec_t'{0,  7, 1,  8, 0, 0, 0, 1, 0, 0, 0, 1});
        tbl.push_back(vec_t'{0, 13, 1,  0, 3, 1, 0, 1, 0, 0, 0, 1});
        tbl.push_back(vec_t'{0, 14, 1, 16, 4, 1, 1, 1, 1, 3, 0, 1});
        tbl.push_back(vec_t'{0, 23, 1, 26, 4, 1, 1, 1, 1, 6, 0, 1});
        tbl.push_back(vec_t'{0, 24, 1, 42, 5, 1, 0, 1, 0, 0, 0, 1});
        tbl.push_back(vec_t'{0, 25, 0,  0, 0, 0, 0, 1, 0, 0, 0, 1});
        tbl.push_back(vec_t'{0, 26, 0,  0, 0, 0, 0, 0, 1, 7, 0, 1});
        tbl.push_back(vec_t'{0, 27, 0,  0, 0, 0, 0, 0, 0, 0, 1, 1});
        tbl.push_back(vec_t'{0, 28, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back(vec_t'{1,  1, 1,  0, 0, 0, 0, 0, 0, 0, 0, 1});
        tbl.push_back(vec_t'{1,  3, 1,  2, 0, 0, 1, 1, 1, 0, 0, 1});
        tbl.push_back(vec_t'{1,  4, 1,  3, 0, 0, 1, 1, 1, 1, 0, 1});
        tbl.push_back(vec_t'{1,  6, 0,  0, 0, 0, 0, 0, 1, 3, 0, 1});
        tbl.push_back(vec_t'{1,  7, 0,  0, 0, 0, 0, 0, 0, 0, 1, 1});
        tbl.push_back(vec_t'{1,  8, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0});

        set_cfg(0);
        @(negedge clk);
        chk("reset busy", m_busy, 0);
        chk("reset done", m_done, 0);
        chk("reset rd_valid", m_rv, 0);
        chk("reset in_addr", m_in, 0);
        chk("reset out_we", m_we, 0);
        @(negedge clk); rst = 1'b1;

        run(0, 0, 0, 0);
        check_vecs();

        set_cfg(1);
        run(0, 0, 0, 0);
        check_vecs();

        set_cfg(0);
        run(5, 3, 0, 0);
        run(0, 0, 10, 0);
        run(0, 0, 0, 1);

        // Abort at cycle 10 with an asynchronous reset.
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        #2;
        chk("pre-abort busy", m_busy, 1);
        chk("pre-abort in_addr", m_in, 10);
        rst = 1'b0; #1;
        chk("abort busy", m_busy, 0);
        chk("abort rd_valid", m_rv, 0);
        chk("abort in_addr", m_in, 0);
        chk("abort w_addr", m_w, 0);
        chk("abort acc_en", m_ae, 0);
        chk("abort acc_first", m_af, 0);
        chk("abort out_we", m_we, 0);
        chk("abort out_addr", m_oa, 0);
        dn_cnt = 0; bz_cnt = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (10) begin
            @(negedge clk);
            dn_cnt += m_done;
            bz_cnt += m_busy;
        end
        chk("done after abort", dn_cnt, 0);
        chk("busy after abort", bz_cnt, 0);
        run(0, 0, 0, 0);
        chk("restart first in_addr", tr[1].in, 0);
        chk("restart first rd_valid", tr[1].rv, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
